// File: rtl/ans_symbol_model.sv
// Frequency-model stage for ans_encoder: programmable symbol count table, sequential
// cumulative-table build, and a 1-deep symbol -> (count, cumulative) output register.
// Optional macro ANS_MODEL_ZERO_CHECK_EN drops zero-count symbols and flags err.
module ans_symbol_model #(
  parameter int NSYM    = 16,
  parameter int COUNT_W = 4,
  parameter int CUM_W   = 16,
  parameter int SYM_W   = $clog2(NSYM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic               cfg_wr,
  input  logic [SYM_W-1:0]   cfg_sym,
  input  logic [COUNT_W-1:0] cfg_count,
  input  logic               cfg_build,
  output logic               busy,
  output logic               ready_tbl,
  output logic               err,
  input  logic [SYM_W-1:0]   sym_in,
  input  logic               sym_vld,
  output logic               sym_rdy,
  output logic [COUNT_W-1:0] s_count,
  output logic [CUM_W-1:0]   s_cumulative,
  output logic [CUM_W-1:0]   total_count,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [1:0]         state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUILD = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  localparam logic [SYM_W-1:0] LAST_IDX = SYM_W'(NSYM - 1);

  logic [1:0]         state;
  logic [SYM_W-1:0]   idx;
  logic [CUM_W-1:0]   acc;
  logic [CUM_W-1:0]   acc_next;
  logic [COUNT_W-1:0] count_tbl [NSYM];
  logic [CUM_W-1:0]   cum_tbl   [NSYM];

  logic accept;
  logic load;
  logic zero_hit;

  // Handshake: a symbol transfers on a cycle where sym_vld and sym_rdy are both
  // high at the rising edge; an output transfers when out_vld and out_rdy are both
  // high. sym_rdy only rises in RUN with ena, and never waits on a full register
  // that is being drained in the same cycle.
  assign sym_rdy   = ena && (state == RUN) && (!out_vld || out_rdy);
  assign accept    = sym_vld && sym_rdy;
  assign busy      = (state == BUILD);
  assign ready_tbl = (state == RUN);
  assign state_dbg = state;
  assign acc_next  = acc + CUM_W'(count_tbl[idx]);

`ifdef ANS_MODEL_ZERO_CHECK_EN
  // The encoder cannot code a zero-probability symbol, so it is swallowed here.
  assign zero_hit = accept && (count_tbl[sym_in] == '0);
  assign load     = accept && !zero_hit;
`else
  assign zero_hit = 1'b0;
  assign load     = accept;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      idx          <= '0;
      acc          <= '0;
      total_count  <= '0;
      s_count      <= '0;
      s_cumulative <= '0;
      out_vld      <= 1'b0;
      err          <= 1'b0;
      for (int i = 0; i < NSYM; i++) begin
        count_tbl[i] <= '0;
        cum_tbl[i]   <= '0;
      end
    end else if (ena) begin
      // Table writes land before a same-cycle build starts reading the table.
      if (cfg_wr && (state != BUILD)) begin
        count_tbl[cfg_sym] <= cfg_count;
      end

      case (state)
        IDLE: begin
          if (cfg_build) begin
            state <= BUILD;
            idx   <= '0;
            acc   <= '0;
          end
        end
        BUILD: begin
          cum_tbl[idx] <= acc;
          acc          <= acc_next;
          idx          <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            total_count <= acc_next;
            if (acc_next == '0) begin
              err   <= 1'b1;
              state <= IDLE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          // A write makes the cumulative table stale; a pending output survives.
          if (cfg_wr) begin
            state <= IDLE;
          end else if (cfg_build) begin
            state <= BUILD;
            idx   <= '0;
            acc   <= '0;
          end
        end
        default: state <= IDLE;
      endcase

      if (load) begin
        s_count      <= count_tbl[sym_in];
        s_cumulative <= cum_tbl[sym_in];
        out_vld      <= 1'b1;
      end else if (out_vld && out_rdy) begin
        out_vld <= 1'b0;
      end

      if (zero_hit) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ans_symbol_model.sv
// Directed bench for ans_symbol_model: vector table for the streaming handshake
// plus hand-written sequences for build, reset, enable and reconfiguration cases.
module tb_ans_symbol_model;

  logic        clk = 1'b0;
  logic        rst, ena, cfg_wr, cfg_build, sym_vld, out_rdy;
  logic [3:0]  cfg_sym, cfg_count, sym_in;
  logic        busy, ready_tbl, err, sym_rdy, out_vld;
  logic [3:0]  s_count;
  logic [15:0] s_cumulative, total_count;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int busy_cycles;

  typedef struct {
    logic        vld;
    logic [3:0]  sym;
    logic        ordy;
    logic        e_rdy;
    logic        e_ovld;
    logic [3:0]  e_cnt;
    logic [15:0] e_cum;
  } vec_t;

  vec_t vecs [8];

  ans_symbol_model dut (
    .clk(clk), .rst(rst), .ena(ena),
    .cfg_wr(cfg_wr), .cfg_sym(cfg_sym), .cfg_count(cfg_count), .cfg_build(cfg_build),
    .busy(busy), .ready_tbl(ready_tbl), .err(err),
    .sym_in(sym_in), .sym_vld(sym_vld), .sym_rdy(sym_rdy),
    .s_count(s_count), .s_cumulative(s_cumulative), .total_count(total_count),
    .out_vld(out_vld), .out_rdy(out_rdy), .state_dbg(state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0] sym, input logic [3:0] cnt);
    cfg_wr = 1'b1; cfg_sym = sym; cfg_count = cnt;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic send_sym(input logic [3:0] sym);
    sym_vld = 1'b1; sym_in = sym;
    tick();
    sym_vld = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " ready_tbl"}, ready_tbl, 0);
    check({tag, " out_vld"}, out_vld, 0);
    check({tag, " s_count"}, s_count, 0);
    check({tag, " s_cum"}, s_cumulative, 0);
    check({tag, " total"}, total_count, 0);
    check({tag, " err"}, err, 0);
    check({tag, " sym_rdy"}, sym_rdy, 0);
    check({tag, " state"}, state_dbg, 0);
  endtask

  initial begin
    // Stream 0,1,2,0 with out_rdy 1,0,1,1,0,1,1,1 on table {4,8,4,0..}
    vecs[0] = '{1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 16'd0};
    vecs[1] = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 4'd4, 16'd0};
    vecs[2] = '{1'b1, 4'd1, 1'b1, 1'b1, 1'b1, 4'd4, 16'd0};
    vecs[3] = '{1'b1, 4'd2, 1'b1, 1'b1, 1'b1, 4'd8, 16'd4};
    vecs[4] = '{1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 4'd4, 16'd12};
    vecs[5] = '{1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 4'd4, 16'd12};
    vecs[6] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b1, 4'd4, 16'd0};
    vecs[7] = '{1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0, 16'd0};

    rst = 1'b1; ena = 1'b1; cfg_wr = 1'b0; cfg_build = 1'b0; cfg_sym = '0; cfg_count = '0;
    sym_vld = 1'b0; sym_in = '0; out_rdy = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check_all_zero("reset");

    // Load table and build
    cfg_write(4'd0, 4'd4);
    cfg_write(4'd1, 4'd8);
    cfg_write(4'd2, 4'd4);
    cfg_build = 1'b1;
    tick();
    cfg_build = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      busy_cycles++;
      tick();
    end
    check("build busy_cycles", busy_cycles, 16);
    check("build ready_tbl", ready_tbl, 1);
    check("build total", total_count, 16);
    check("build err", err, 0);

    // Single symbol, latency 1
    send_sym(4'd2);
    check("sym2 out_vld", out_vld, 1);
    check("sym2 s_count", s_count, 4);
    check("sym2 s_cum", s_cumulative, 12);
    tick();
    check("sym2 drained", out_vld, 0);

    // Table-driven stream with back-pressure
    for (int i = 0; i < 8; i++) begin
      sym_vld = vecs[i].vld; sym_in = vecs[i].sym; out_rdy = vecs[i].ordy;
      #1;
      check($sformatf("vec%0d sym_rdy", i), sym_rdy, vecs[i].e_rdy);
      check($sformatf("vec%0d out_vld", i), out_vld, vecs[i].e_ovld);
      if (vecs[i].e_ovld) begin
        check($sformatf("vec%0d s_count", i), s_count, vecs[i].e_cnt);
        check($sformatf("vec%0d s_cum", i), s_cumulative, vecs[i].e_cum);
      end
      tick();
    end
    sym_vld = 1'b0;

    // Zero-count symbol
    out_rdy = 1'b1;
    send_sym(4'd5);
`ifdef ANS_MODEL_ZERO_CHECK_EN
    check("zero out_vld", out_vld, 0);
    check("zero err", err, 1);
`else
    check("zero out_vld", out_vld, 1);
    check("zero s_count", s_count, 0);
    check("zero s_cum", s_cumulative, 16);
    check("zero err", err, 0);
`endif
    tick();

    // ena low for 3 cycles with a pending output
    out_rdy = 1'b0;
    send_sym(4'd1);
    check("ena pre out_vld", out_vld, 1);
    ena = 1'b0; out_rdy = 1'b1; sym_vld = 1'b1; sym_in = 4'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("ena%0d sym_rdy", i), sym_rdy, 0);
      tick();
      check($sformatf("ena%0d out_vld", i), out_vld, 1);
      check($sformatf("ena%0d s_count", i), s_count, 8);
      check($sformatf("ena%0d s_cum", i), s_cumulative, 4);
    end
    ena = 1'b1; sym_vld = 1'b0; out_rdy = 1'b0;

    // cfg_wr in RUN keeps the held output
    cfg_write(4'd3, 4'd2);
    check("wr_run ready_tbl", ready_tbl, 0);
    check("wr_run out_vld", out_vld, 1);
    check("wr_run s_count", s_count, 8);
    check("wr_run s_cum", s_cumulative, 4);
    out_rdy = 1'b1;
    #1;
    check("wr_run sym_rdy", sym_rdy, 0);
    tick();
    check("wr_run drained", out_vld, 0);

    // Reset during BUILD at idx=7
    cfg_build = 1'b1;
    tick();
    cfg_build = 1'b0;
    repeat (7) tick();
    check("midbuild busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midbuild_rst");

    // Build of an all-zero table (reset cleared it)
    cfg_build = 1'b1;
    tick();
    cfg_build = 1'b0;
    repeat (16) tick();
    check("zbuild err", err, 1);
    check("zbuild state", state_dbg, 0);
    check("zbuild sym_rdy", sym_rdy, 0);
    check("zbuild ready_tbl", ready_tbl, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst clears err", err, 0);

    // Write and build in the same cycle: build sees the new count
    cfg_wr = 1'b1; cfg_sym = 4'd7; cfg_count = 4'd3; cfg_build = 1'b1;
    tick();
    cfg_wr = 1'b0; cfg_build = 1'b0;
    repeat (16) tick();
    check("wrbuild ready_tbl", ready_tbl, 1);
    check("wrbuild total", total_count, 3);
    check("wrbuild err", err, 0);
    out_rdy = 1'b0;
    send_sym(4'd7);
    check("sym7 s_count", s_count, 3);
    check("sym7 s_cum", s_cumulative, 0);

    // Rebuild from RUN retains the pending output
    cfg_build = 1'b1;
    tick();
    cfg_build = 1'b0;
    check("rebuild busy", busy, 1);
    check("rebuild out_vld", out_vld, 1);
    check("rebuild s_count", s_count, 3);
    out_rdy = 1'b1;
    tick();
    check("rebuild drained", out_vld, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ans_symbol_model.md
Name: ans_symbol_model

Overview:
- Frequency-model stage that sits directly upstream of ans_encoder.
- Holds a programmable 16-entry symbol count table and builds its cumulative (prefix-sum) table with a sequential build state machine.
- Translates a stream of 4-bit symbols into (s_count, s_cumulative, total_count) tuples over a valid/ready handshake.
- Its output port maps 1:1 onto the encoder's s_count/s_cumulative/total_count/in_vld/in_rdy.

Parameters:
- NSYM, 16, number of symbols; symbol index is clog2(NSYM)=4 bits.
- COUNT_W, 4, width of one symbol count; matches encoder s_count.
- CUM_W, 16, width of cumulative and total counts; matches encoder.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- ena  in  1  enable; when low the block holds all state.
- cfg_wr  in  1  table write strobe.
- cfg_sym  in  4  table index to write.
- cfg_count  in  COUNT_W  count value to write.
- cfg_build  in  1  pulse that starts a cumulative-table build.
- busy  out  1  high in BUILD.
- ready_tbl  out  1  high in RUN; table valid.
- err  out  1  sticky error flag.
- sym_in  in  4  input symbol.
- sym_vld  in  1  input valid.
- sym_rdy  out  1  input ready.
- s_count  out  COUNT_W  count of the accepted symbol.
- s_cumulative  out  CUM_W  cumulative count below the accepted symbol.
- total_count  out  CUM_W  sum of all counts.
- out_vld  out  1  output valid.
- out_rdy  in  1  output ready (the encoder's in_rdy).

Behaviour:
- Reset (rst=1 at clk edge; overrides ena): every table count and cumulative entry = 0, total_count=0, state=IDLE.
- Outputs at reset: s_count=0, s_cumulative=0, out_vld=0, err=0, busy=0, ready_tbl=0, sym_rdy=0.
- Reset mid-BUILD or mid-RUN aborts immediately; a pending output is discarded.
- ena=0: no state, table, or output register changes; sym_rdy forced 0; out_vld and data hold their values.
- States: IDLE, BUILD, RUN.
- IDLE:
  - cfg_wr writes count[cfg_sym] <= cfg_count.
  - cfg_build moves to BUILD with idx=0, acc=0.
  - If cfg_wr and cfg_build occur in the same cycle, the write lands first and the build uses the new value.
- BUILD (exactly NSYM cycles):
  - Each cycle: cum[idx] <= acc; acc <= acc + count[idx]; idx++.
  - On idx=NSYM-1, total_count <= final acc.
  - If the final total is 0, set err and go to IDLE; otherwise go to RUN.
  - cfg_wr and cfg_build are ignored in BUILD.
  - Adds are zero-extended to CUM_W; the maximum 16*15=240 cannot wrap.
- RUN:
  - sym_rdy = !out_vld | out_rdy, so there is no bubble under continuous flow.
  - On sym_vld & sym_rdy, the output register loads s_count=count[sym_in] and s_cumulative=cum[sym_in], and out_vld=1. Latency is 1 cycle.
  - Output is cleared when out_vld & out_rdy and no new load occurs that cycle.
  - A simultaneous load and drain replaces the output.
  - Data is stable while out_vld & !out_rdy.
- cfg_wr in RUN:
  - Writes the table and moves to IDLE (cumulative table is stale).
  - sym_rdy drops the next cycle.
  - A pending output stays valid and unchanged until drained.
- cfg_build in RUN without cfg_wr: rebuild (go to BUILD); the pending output is retained.
- err clears only on rst.

Optional Feature:
- Macro: ANS_MODEL_ZERO_CHECK_EN.
- Defined: in RUN, an accepted symbol with count 0 is consumed but not forwarded (out_vld is not set by it) and err is set. The encoder cannot encode zero-probability symbols.
- Undefined: such a symbol is forwarded with s_count=0; err is set only by a zero-total build.

Test Plan:
- Load counts sym0=4, sym1=8, sym2=4, others 0; pulse cfg_build -> busy for exactly 16 cycles, then ready_tbl=1 and total_count=16.
- With that table, send sym2 (out_rdy=1) -> one cycle later s_count=4, s_cumulative=12, out_vld=1.
- Send symbols 0,1,2,0 back-to-back while out_rdy toggles 1,0,1,1,0,1 -> outputs (4,0),(8,4),(4,12),(4,0) in order with no drops or duplicates; data stable while stalled; sym_rdy=1 every cycle when out_rdy=1.
- Build with all counts 0 -> err=1, state IDLE, sym_rdy=0; a later rst clears err.
- Send sym5 (count 0) -> with macro: no output, err=1. Without macro: s_count=0, s_cumulative=16, err stays 0.
- Cover the remaining controls:
  - Assert rst during BUILD at idx=7 -> all outputs 0 next cycle.
  - ena=0 for 3 cycles in RUN with out_vld=1 -> outputs frozen.
  - cfg_wr in RUN -> ready_tbl=0 and the held output is still delivered.
